adxl362_spi_engine: RTL and testbench
=====================================

ADXL362_SPI_ENGINE -- requirements
Module: adxl362_spi_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register address width.
REQ-002 SHALL have parameter REG_COUNT, default 64, number of addressable registers; auto-increment wrap limit, 2..2^ADDR_WIDTH.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SCLK/nCS/MOSI, minimum 2.
REQ-004 SHALL have port clk_16mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have ports SCLK, MOSI, nCS  input  1 each  SPI from the host, asynchronous to clk_16mhz, mode 0 (CPOL=0, CPHA=0).
REQ-007 SHALL have port MISO  output  1  SPI serial data to the host, MSB first.
REQ-008 SHALL have ports address  output  ADDR_WIDTH  and data_write  output  8  register-file address and write data.
REQ-009 SHALL have ports write  output  1  register write strobe, and read  output  1  register read strobe.
REQ-010 SHALL have port data_read  input  8  register read data, valid one cycle after read.
REQ-011 SHALL have ports data_fifo_read  input  8  sample-FIFO head byte, and data_fifo_pop  output  1  FIFO pop strobe.
REQ-012 SHALL have ports busy  output  1  transaction active, and cmd_error  output  1  one-cycle pulse on an unknown command.

Function
REQ-013 SHALL synchronise SCLK, nCS and MOSI through SYNC_STAGES flops; all decisions use synchronised copies only.
REQ-014 SHALL detect SCLK rising edges (sample MOSI) and falling edges (shift MISO) from the synchronised SCLK; SCLK at most clk_16mhz/8.
REQ-015 SHALL count bits 0..7 per byte; the 8th rising edge completes a byte ("byte-done", a one-cycle internal event).
REQ-016 SHALL implement states IDLE, CMD, ADDR, WR_DATA, RD_DATA, FIFO_DATA, IGNORE.
REQ-017 SHALL go IDLE->CMD when synchronised nCS falls; busy = 1 in every state except IDLE.
REQ-018 In CMD, SHALL decode on byte-done: 0x0A->ADDR (write), 0x0B->ADDR (read), 0x0D->FIFO_DATA; any other value->IGNORE with cmd_error pulsed for one cycle.
REQ-019 In ADDR, SHALL on byte-done load address from the low ADDR_WIDTH bits of the received byte and go WR_DATA or RD_DATA per the command.
REQ-020 In WR_DATA, SHALL on each byte-done drive data_write = received byte and pulse write for exactly one cycle with the current address, then increment address the following cycle.
REQ-021 In RD_DATA, SHALL pulse read one cycle after entry and one cycle after each data-byte-done increment, capture data_read the next cycle into the shift-out register, and present MISO = bit 7 before the next SCLK rising edge.
REQ-022 In RD_DATA, SHALL shift MISO on each SCLK falling edge and increment address after each data-byte-done.
REQ-023 In FIFO_DATA, SHALL load data_fifo_read into the shift-out register at entry and after each byte-done, pulsing data_fifo_pop for one cycle after each byte-done; no address byte is consumed.
REQ-024 Address increment SHALL wrap from REG_COUNT-1 to 0.
REQ-025 MISO SHALL be 0 in IDLE, CMD, ADDR, WR_DATA and IGNORE.
REQ-026 Synchronised nCS rising SHALL return any state to IDLE the next cycle and discard a partial byte: no write, read or pop is issued for it.
REQ-027 Byte-done and nCS rising in the same cycle: the byte-done action completes, then the block goes IDLE.
REQ-028 SHALL generate at most one of write, read and data_fifo_pop per cycle.

Reset
REQ-029 When rst = 1 on a clk_16mhz edge, SHALL enter IDLE and clear bit count, shift registers and synchronisers (nCS synchronisers to 1).
REQ-030 Reset values SHALL be: MISO 0, address 0, data_write 0, write 0, read 0, data_fifo_pop 0, busy 0, cmd_error 0.
REQ-031 rst asserted mid-transaction SHALL abort it with no further strobes; a new transaction requires a fresh nCS falling edge.

Verification
REQ-032 Write burst 0x0A,0x20,0x11,0x22 -> write pulses at address 0x20 with 0x11 and at 0x21 with 0x22, one cycle each.
REQ-033 Read 0x0B,0x00 with register 0x00=0xAD and 0x01=0x1D -> MISO bytes 0xAD then 0x1D; read pulses at 0x00 and 0x01.
REQ-034 REG_COUNT=64 write burst from 0x3F with two data bytes -> writes at 0x3F, then 0x00.
REQ-035 FIFO read 0x0D with FIFO head 0x5A then 0xA5 -> MISO 0x5A, 0xA5; two data_fifo_pop pulses.
REQ-036 Command 0x55 -> cmd_error pulse, MISO 0, no strobes until nCS high; nCS raised after 4 bits of a write data byte -> no write, IDLE.
REQ-037 rst asserted during a read burst -> all outputs at reset values next cycle; the next 0x0A transaction works normally.

Source files
------------

// File: rtl/adxl362_spi_engine.sv
// ADXL362-style SPI slave engine.
// Decodes host SPI transactions (mode 0) into register-file writes/reads and
// sample-FIFO pops; serialises read/FIFO data back on MISO, MSB first.
// Ports:
//   clk_16mhz, rst       - sole clock, synchronous active-high reset
//   SCLK, MOSI, nCS      - asynchronous SPI inputs from the host
//   MISO                 - serial data to the host
//   address, data_write  - register-file address / write data
//   write, read          - one-cycle register strobes (data_read valid one cycle after read)
//   data_fifo_read       - FIFO head byte; data_fifo_pop pops it
//   busy                 - transaction active; cmd_error pulses on an unknown command
module adxl362_spi_engine #(
  parameter int ADDR_WIDTH  = 6,
  parameter int REG_COUNT   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_16mhz,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  nCS,
  output logic                  MISO,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data_write,
  output logic                  write,
  output logic                  read,
  input  logic [7:0]            data_read,
  input  logic [7:0]            data_fifo_read,
  output logic                  data_fifo_pop,
  output logic                  busy,
  output logic                  cmd_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_DATA, S_FIFO_DATA, S_IGNORE
  } state_e;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, mosi_sync_q, vld_q;
  logic sclk_prev_q, ncs_prev_q, armed_q;
  logic sclk_s, ncs_s, mosi_s;
  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // vld_q marks when the chain holds a real sample again after reset; armed_q
  // then requires nCS to be seen high, so a host still holding nCS low across
  // a reset cannot look like a fresh falling edge.
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      if (vld_q[SYNC_STAGES-1] && ncs_s) armed_q <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q & armed_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  // Transaction state
  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [7:0]            dw_q, dw_d;
  logic                  cmd_rd_q, cmd_rd_d;
  logic                  write_q, write_d, read_q, read_d, pop_q, pop_d;
  logic                  err_q, err_d, cap_q, cap_d;
  logic [7:0]            rx_byte;

  assign rx_byte   = {rx_q, mosi_s};
  assign addr_next = (addr_q == ADDR_WIDTH'(REG_COUNT - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    dw_d      = dw_q;
    cmd_rd_d  = cmd_rd_q;
    write_d   = 1'b0;
    read_d    = 1'b0;
    pop_d     = 1'b0;
    err_d     = 1'b0;
    // A read or pop strobe is followed one cycle later by a capture of the
    // returned byte into the shift-out register.
    cap_d     = read_q | pop_q;

    if (write_q) addr_d = addr_next;

    if (state_q == S_IDLE) begin
      bit_cnt_d = '0;
      tx_d      = '0;
      if (ncs_fall) state_d = S_CMD;
    end else begin
      // No shift on the falling edge that ends a byte (bit count back at 0),
      // so a freshly loaded byte keeps bit 7 on MISO until its first rise.
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else if (sclk_fall && bit_cnt_q != 3'd0) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (cap_q) tx_d = (state_q == S_FIFO_DATA) ? data_fifo_read : data_read;

      if (sclk_rise && bit_cnt_q == 3'd7) begin
        unique case (state_q)
          S_CMD: begin
            unique case (rx_byte)
              8'h0A:   begin state_d = S_ADDR; cmd_rd_d = 1'b0; end
              8'h0B:   begin state_d = S_ADDR; cmd_rd_d = 1'b1; end
              8'h0D:   begin state_d = S_FIFO_DATA; tx_d = data_fifo_read; end
              default: begin state_d = S_IGNORE; err_d = 1'b1; end
            endcase
          end
          S_ADDR: begin
            addr_d  = rx_byte[ADDR_WIDTH-1:0];
            state_d = cmd_rd_q ? S_RD_DATA : S_WR_DATA;
            read_d  = cmd_rd_q;
          end
          S_WR_DATA: begin
            dw_d    = rx_byte;
            write_d = 1'b1;
          end
          S_RD_DATA: begin
            addr_d = addr_next;
            read_d = 1'b1;
          end
          S_FIFO_DATA: pop_d = 1'b1;
          default: ;
        endcase
      end

      // Any byte-done action above still completes when nCS rises together.
      if (ncs_rise) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      dw_q      <= '0;
      cmd_rd_q  <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      pop_q     <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      dw_q      <= dw_d;
      cmd_rd_q  <= cmd_rd_d;
      write_q   <= write_d;
      read_q    <= read_d;
      pop_q     <= pop_d;
      err_q     <= err_d;
      cap_q     <= cap_d;
    end
  end

  assign MISO          = ((state_q == S_RD_DATA) || (state_q == S_FIFO_DATA)) ? tx_q[7] : 1'b0;
  assign address       = addr_q;
  assign data_write    = dw_q;
  assign write         = write_q;
  assign read          = read_q;
  assign data_fifo_pop = pop_q;
  assign busy          = (state_q != S_IDLE);
  assign cmd_error     = err_q;

endmodule

// File: tb/tb_adxl362_spi_engine.sv
// Testbench for adxl362_spi_engine: host SPI driver, register-file and FIFO
// models, strobe scoreboards and a table of transactions.
module tb_adxl362_spi_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0, MOSI = 1'b0, nCS = 1'b1;
  logic       MISO;
  logic [5:0] address;
  logic [7:0] data_write, data_read, data_fifo_read;
  logic       write, read, data_fifo_pop, busy, cmd_error;

  always #5 clk = ~clk;

  adxl362_spi_engine #(.ADDR_WIDTH(6), .REG_COUNT(64), .SYNC_STAGES(2)) dut (
    .clk_16mhz(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .nCS(nCS), .MISO(MISO),
    .address(address), .data_write(data_write), .write(write), .read(read),
    .data_read(data_read), .data_fifo_read(data_fifo_read),
    .data_fifo_pop(data_fifo_pop), .busy(busy), .cmd_error(cmd_error)
  );

  // Register file (read-only stub) and sample FIFO models
  logic [7:0] regs [64];
  logic [7:0] fifo_mem [8];
  int         fifo_rd = 0;

  initial data_read = '0;
  always @(posedge clk) if (read) data_read <= regs[address];
  assign data_fifo_read = fifo_mem[fifo_rd % 8];
  always @(posedge clk) if (data_fifo_pop) fifo_rd <= fifo_rd + 1;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboards
  logic [13:0] exp_wr_q [$];
  logic [5:0]  exp_rd_q [$];
  bit          exp_pop_q [$];
  bit          exp_err_q [$];
  logic [7:0]  exp_miso_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      logic [13:0] e;
      logic [5:0]  ra;
      if (write | read | data_fifo_pop)
        check("strobe_onehot", $countones({write, read, data_fifo_pop}), 1);
      if (write) begin
        check("write_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) begin
          e = exp_wr_q.pop_front();
          check("write_addr", address, e[13:8]);
          check("write_data", data_write, e[7:0]);
        end
      end
      if (read) begin
        check("read_expected", exp_rd_q.size() > 0, 1);
        if (exp_rd_q.size() > 0) begin
          ra = exp_rd_q.pop_front();
          check("read_addr", address, ra);
        end
      end
      if (data_fifo_pop) begin
        check("pop_expected", exp_pop_q.size() > 0, 1);
        if (exp_pop_q.size() > 0) void'(exp_pop_q.pop_front());
      end
      if (cmd_error) begin
        check("cmd_error_expected", exp_err_q.size() > 0, 1);
        if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
      end
    end
  end

  // Host: shift nbits of tx MSB first, sampling MISO just before each rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      repeat (8) @(negedge clk);
      rx[i] = MISO;
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic end_txn();
    repeat (8) @(negedge clk);
    nCS = 1'b1;
    repeat (16) @(negedge clk);
    check("busy_after_ncs", busy, 0);
    check("writes_left", exp_wr_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
    check("pops_left", exp_pop_q.size(), 0);
    check("errors_left", exp_err_q.size(), 0);
  endtask

  typedef struct {
    int                 nb;
    logic [0:3][7:0]    tx;
    logic [0:3][7:0]    miso;
    int                 nwr;
    logic [0:1][5:0]    wa;
    logic [0:1][7:0]    wd;
    int                 nrd;
    logic [0:2][5:0]    ra;
    int                 npop;
    bit                 err;
  } vec_t;

  vec_t vecs [7];

  task automatic setv(input int i, input int nb, input logic [0:3][7:0] tx,
                      input logic [0:3][7:0] miso, input int nwr,
                      input logic [0:1][5:0] wa, input logic [0:1][7:0] wd,
                      input int nrd, input logic [0:2][5:0] ra,
                      input int npop, input bit err);
    vecs[i].nb = nb;   vecs[i].tx = tx;   vecs[i].miso = miso;
    vecs[i].nwr = nwr; vecs[i].wa = wa;   vecs[i].wd = wd;
    vecs[i].nrd = nrd; vecs[i].ra = ra;   vecs[i].npop = npop;
    vecs[i].err = err;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rx, em;
    for (int k = 0; k < v.nwr; k++) exp_wr_q.push_back({v.wa[k], v.wd[k]});
    for (int k = 0; k < v.nrd; k++) exp_rd_q.push_back(v.ra[k]);
    for (int k = 0; k < v.npop; k++) exp_pop_q.push_back(1'b1);
    if (v.err) exp_err_q.push_back(1'b1);
    for (int b = 0; b < v.nb; b++) exp_miso_q.push_back(v.miso[b]);
    nCS = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < v.nb; b++) begin
      spi_xfer(v.tx[b], 8, rx);
      em = exp_miso_q.pop_front();
      check("miso_byte", rx, em);
    end
    end_txn();
  endtask

  initial begin
    logic [7:0] rx;
    for (int i = 0; i < 64; i++) regs[i] = 8'(i) ^ 8'hC0;
    regs[0] = 8'hAD; regs[1] = 8'h1D; regs[63] = 8'h77;
    fifo_mem[0] = 8'h5A; fifo_mem[1] = 8'hA5;
    for (int i = 2; i < 8; i++) fifo_mem[i] = 8'hC3;

    //   idx nb tx                                 miso                              nwr wa               wd               nrd ra                     pop err
    setv(0, 4, {8'h0A,8'h20,8'h11,8'h22}, '0,                                   2, {6'h20,6'h21}, {8'h11,8'h22}, 0, '0,                    0, 0);
    setv(1, 4, {8'h0A,8'h3F,8'h33,8'h44}, '0,                                   2, {6'h3F,6'h00}, {8'h33,8'h44}, 0, '0,                    0, 0);
    setv(2, 4, {8'h0B,8'h00,8'hFF,8'hFF}, {8'h00,8'h00,8'hAD,8'h1D},           0, '0,            '0,            3, {6'h00,6'h01,6'h02},  0, 0);
    setv(3, 4, {8'h0B,8'h3F,8'hFF,8'hFF}, {8'h00,8'h00,8'h77,8'hAD},           0, '0,            '0,            3, {6'h3F,6'h00,6'h01},  0, 0);
    setv(4, 3, {8'h0D,8'h00,8'h00,8'h00}, {8'h00,8'h5A,8'hA5,8'h00},           0, '0,            '0,            0, '0,                    2, 0);
    setv(5, 3, {8'h55,8'hFF,8'hFF,8'h00}, '0,                                   0, '0,            '0,            0, '0,                    0, 1);
    setv(6, 3, {8'h0A,8'hC5,8'h9A,8'h00}, '0,                                   1, {6'h05,6'h00}, {8'h9A,8'h00}, 0, '0,                    0, 0);

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_address", address, 0);
    check("rst_data_write", data_write, 0);
    check("rst_write", write, 0);
    check("rst_read", read, 0);
    check("rst_pop", data_fifo_pop, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_error", cmd_error, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // nCS raised mid data byte: only the complete byte is written
    exp_wr_q.push_back({6'h10, 8'h66});
    nCS = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_in_txn", busy, 1);
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h10, 8, rx);
    spi_xfer(8'h66, 8, rx);
    spi_xfer(8'h77, 4, rx);
    end_txn();

    // Reset during a read burst, nCS still held low through and after reset
    exp_rd_q.push_back(6'h00);
    nCS = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'hFF, 3, rx);
    rst = 1'b1;
    @(negedge clk);
    check("abort_miso", MISO, 0);
    check("abort_address", address, 0);
    check("abort_data_write", data_write, 0);
    check("abort_strobes", {write, read, data_fifo_pop, cmd_error}, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    check("no_restart_without_fall", busy, 0);
    nCS = 1'b1;
    repeat (8) @(negedge clk);
    run_vec(vecs[6]);

    check("miso_left", exp_miso_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
